// File: rtl/sat_add_serial_if.sv
// Handshake/operand bundle for the bit-serial saturating adder.
// Carries clr_ovf/ovf_sticky only when SAT_ADD_STICKY_OVF_EN is defined.
interface sat_add_serial_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             busy;
  logic             done;
`ifdef SAT_ADD_STICKY_OVF_EN
  logic             clr_ovf;
  logic             ovf_sticky;

  modport master (
    output start, A, B, cin, clr_ovf,
    input  S, cout, busy, done, ovf_sticky
  );

  modport slave (
    input  start, A, B, cin, clr_ovf,
    output S, cout, busy, done, ovf_sticky
  );
`else
  modport master (
    output start, A, B, cin,
    input  S, cout, busy, done
  );

  modport slave (
    input  start, A, B, cin,
    output S, cout, busy, done
  );
`endif

endinterface

// File: rtl/sat_add_serial.sv
// Bit-serial saturating adder: S = A + B + cin (LSB first, one bit per clock), clamped to all-ones on carry-out.
// Optional feature macro SAT_ADD_STICKY_OVF_EN adds clr_ovf / ovf_sticky.
module sat_add_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  sat_add_serial_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic             sum_bit_c;
  logic             carry_nxt_c;
  logic [WIDTH-1:0] sum_nxt_c;
  logic             last_step_c;

  // One full-adder slice. Sum bits enter the MSB of the A register as A drains out of its LSB,
  // so after WIDTH steps that register holds the raw sum.
  always_comb begin
    sum_bit_c   = a_sr[0] ^ b_sr[0] ^ carry;
    carry_nxt_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    sum_nxt_c   = {sum_bit_c, a_sr[WIDTH-1:1]};
    last_step_c = (state == SHIFT) && (cnt == LAST_CNT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr   <= bus.A;
            b_sr   <= bus.B;
            carry  <= bus.cin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr  <= sum_nxt_c;
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          carry <= carry_nxt_c;
          cnt   <= cnt + CNT_W'(1);
          // Final bit: publish the (possibly clamped) result on the same edge.
          if (last_step_c) begin
            s_q    <= carry_nxt_c ? {WIDTH{1'b1}} : sum_nxt_c;
            cout_q <= carry_nxt_c;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.S    = s_q;
  assign bus.cout = cout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

`ifdef SAT_ADD_STICKY_OVF_EN
  logic ovf_q;

  // A saturating completion beats a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (last_step_c && carry_nxt_c) begin
      ovf_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.ovf_sticky = ovf_q;
`endif

  a_done_busy: assert property (@(posedge clk) disable iff (reset) done_q |-> busy_q);
  a_done_pulse: assert property (@(posedge clk) disable iff (reset) done_q |=> !done_q);

endmodule
